// File: rtl/pc_gen.sv
// Program counter generator: boot/run/halt sequencing, trap and jump redirects,
// sequential advance on accepted fetches, and rejected-target reporting.
module pc_gen #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int unsigned      STEP         = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_ready,
  input  logic            stall,
  input  logic            j_signal,
  input  logic [XLEN-1:0] jump,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt,
  output logic [XLEN-1:0] out,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_prev,
  output logic            flush,
  output logic            misaligned,
  output logic [XLEN-1:0] bad_addr
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  // STEP is a power of two, so STEP-1 masks the bits a legal target keeps clear.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);
  localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);

  state_t          r_state, w_state_next;
  logic [XLEN-1:0] r_out, w_out_next;
  logic [XLEN-1:0] r_prev, w_prev_next;
  logic [XLEN-1:0] r_bad, w_bad_next;
  logic            r_flush, w_flush_next;
  logic            r_mis, w_mis_next;
  logic            w_valid;
  logic            w_accept;
  logic            w_jump_bad;

  assign w_valid    = (r_state == RUN);
  assign w_accept   = w_valid & fetch_ready;
  assign w_jump_bad = |(jump & ALIGN_MASK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= BOOT;
      r_out   <= RESET_VECTOR;
      r_prev  <= RESET_VECTOR;
      r_bad   <= '0;
      r_flush <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_out   <= w_out_next;
      r_prev  <= w_prev_next;
      r_bad   <= w_bad_next;
      r_flush <= w_flush_next;
      r_mis   <= w_mis_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_out_next   = r_out;
    w_prev_next  = r_prev;
    w_bad_next   = r_bad;
    w_flush_next = 1'b0;
    w_mis_next   = 1'b0;

    // pc_prev tracks every handshake, regardless of which redirect wins.
    if (w_accept) begin
      w_prev_next = r_out;
    end

    if (trap) begin
      w_out_next   = trap_vector;
      w_flush_next = 1'b1;
      w_state_next = RUN;
    end else begin
      unique case (r_state)
        BOOT: begin
          w_state_next = RUN;
        end
        RUN: begin
          if (j_signal) begin
            // A rejected target leaves out where it is, even if fetch accepted.
            if (w_jump_bad) begin
              w_mis_next = 1'b1;
              w_bad_next = jump;
            end else begin
              w_out_next   = jump;
              w_flush_next = 1'b1;
            end
          end else if (!stall && w_accept) begin
            w_out_next = r_out + STEP_INC;
          end
          if (halt) begin
            w_state_next = HALTED;
          end
        end
        HALTED: begin
          if (!halt) begin
            w_state_next = RUN;
          end
        end
        default: begin
          w_state_next = BOOT;
        end
      endcase
    end
  end

  assign out        = r_out;
  assign pc_valid   = w_valid;
  assign pc_prev    = r_prev;
  assign flush      = r_flush;
  assign misaligned = r_mis;
  assign bad_addr   = r_bad;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: boot, stall/accept, jumps, traps, halt, wrap and
// mid-stream reset, each checked against hand-computed values.
module tb_pc_gen;

  logic        clk;
  logic        reset;
  logic        fetch_ready;
  logic        stall;
  logic        j_signal;
  logic [31:0] jump;
  logic        trap;
  logic [31:0] trap_vector;
  logic        halt;
  logic [31:0] out;
  logic        pc_valid;
  logic [31:0] pc_prev;
  logic        flush;
  logic        misaligned;
  logic [31:0] bad_addr;

  int n_tests = 0;
  int n_fail  = 0;

  pc_gen #(
    .XLEN(32),
    .RESET_VECTOR(32'h0),
    .STEP(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fetch_ready(fetch_ready),
    .stall(stall),
    .j_signal(j_signal),
    .jump(jump),
    .trap(trap),
    .trap_vector(trap_vector),
    .halt(halt),
    .out(out),
    .pc_valid(pc_valid),
    .pc_prev(pc_prev),
    .flush(flush),
    .misaligned(misaligned),
    .bad_addr(bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    $display("[TB] %0t %s observed=0x%08h expected=0x%08h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; fetch_ready = 1'b1; stall = 1'b0; j_signal = 1'b0;
    jump = '0; trap = 1'b0; trap_vector = '0; halt = 1'b0;
    #1;
    check("rst_out", out, 32'h0);
    check("rst_valid", {31'b0, pc_valid}, 32'd0);
    check("rst_prev", pc_prev, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_mis", {31'b0, misaligned}, 32'd0);
    check("rst_bad", bad_addr, 32'h0);
    step(); step();

    // Boot: one cycle with pc_valid low, then 0, 4, 8.
    reset = 1'b1;
    check("boot_valid", {31'b0, pc_valid}, 32'd0);
    step();
    check("run0_valid", {31'b0, pc_valid}, 32'd1);
    check("run0_out", out, 32'h0);
    check("run0_prev", pc_prev, 32'h0);
    step();
    check("run1_out", out, 32'h4);
    check("run1_prev", pc_prev, 32'h0);
    step();
    check("run2_out", out, 32'h8);
    check("run2_prev", pc_prev, 32'h4);

    // Trap to 0x100 (accept at 0x8 still recorded), then back-pressure.
    trap = 1'b1; trap_vector = 32'h100;
    step();
    trap = 1'b0; fetch_ready = 1'b0;
    check("trap100_out", out, 32'h100);
    check("trap100_flush", {31'b0, flush}, 32'd1);
    check("trap100_prev", pc_prev, 32'h8);
    step(); step(); step();
    check("bp_out", out, 32'h100);
    check("bp_prev", pc_prev, 32'h8);
    check("bp_flush", {31'b0, flush}, 32'd0);
    fetch_ready = 1'b1;
    step();
    check("bp_rel_out", out, 32'h104);
    check("bp_rel_prev", pc_prev, 32'h100);

    // Aligned jump with stall, then a misaligned target.
    fetch_ready = 1'b0; trap = 1'b1; trap_vector = 32'h200;
    step();
    trap = 1'b0;
    check("trap200_out", out, 32'h200);
    stall = 1'b1; j_signal = 1'b1; jump = 32'h400;
    step();
    check("jmp_out", out, 32'h400);
    check("jmp_flush", {31'b0, flush}, 32'd1);
    check("jmp_mis", {31'b0, misaligned}, 32'd0);
    jump = 32'h402;
    step();
    check("bad_out", out, 32'h400);
    check("bad_mis", {31'b0, misaligned}, 32'd1);
    check("bad_flush", {31'b0, flush}, 32'd0);
    check("bad_addr", bad_addr, 32'h402);
    stall = 1'b0; j_signal = 1'b0;
    step();
    check("bad_mis_clr", {31'b0, misaligned}, 32'd0);
    check("bad_addr_keep", bad_addr, 32'h402);

    // Trap beats a simultaneous (misaligned) jump.
    trap = 1'b1; trap_vector = 32'h80; j_signal = 1'b1; jump = 32'h406;
    step();
    trap = 1'b0; j_signal = 1'b0;
    check("tj_out", out, 32'h80);
    check("tj_flush", {31'b0, flush}, 32'd1);
    check("tj_mis", {31'b0, misaligned}, 32'd0);
    check("tj_bad", bad_addr, 32'h402);

    // Halt at 0x300, jump ignored, resume on halt=0.
    trap = 1'b1; trap_vector = 32'h300;
    step();
    trap = 1'b0; halt = 1'b1;
    step();
    check("halt_valid", {31'b0, pc_valid}, 32'd0);
    check("halt_out", out, 32'h300);
    j_signal = 1'b1; jump = 32'h500;
    step();
    check("halt_j_out", out, 32'h300);
    check("halt_j_flush", {31'b0, flush}, 32'd0);
    check("halt_j_valid", {31'b0, pc_valid}, 32'd0);
    j_signal = 1'b0; halt = 1'b0;
    step();
    check("resume_valid", {31'b0, pc_valid}, 32'd1);
    check("resume_out", out, 32'h300);
    halt = 1'b1;
    step();
    check("halt2_valid", {31'b0, pc_valid}, 32'd0);
    halt = 1'b0; trap = 1'b1; trap_vector = 32'h600;
    step();
    trap = 1'b0;
    check("htrap_valid", {31'b0, pc_valid}, 32'd1);
    check("htrap_out", out, 32'h600);
    check("htrap_flush", {31'b0, flush}, 32'd1);

    // Halt with a same-cycle accepted fetch still advances.
    fetch_ready = 1'b1; halt = 1'b1;
    step();
    check("hacc_out", out, 32'h604);
    check("hacc_prev", pc_prev, 32'h600);
    check("hacc_valid", {31'b0, pc_valid}, 32'd0);
    halt = 1'b0; fetch_ready = 1'b0;
    step();
    check("hacc_resume", out, 32'h604);

    // Wrap at the top of the address space.
    fetch_ready = 1'b1; trap = 1'b1; trap_vector = 32'hFFFF_FFFC;
    step();
    trap = 1'b0;
    check("wrap_pre", out, 32'hFFFF_FFFC);
    check("wrap_pre_prev", pc_prev, 32'h604);
    step();
    check("wrap_out", out, 32'h0);
    check("wrap_prev", pc_prev, 32'hFFFF_FFFC);
    step();
    check("wrap_next", out, 32'h4);

    // Asynchronous reset mid-cycle, then a fresh boot.
    #2;
    reset = 1'b0;
    #1;
    check("arst_out", out, 32'h0);
    check("arst_prev", pc_prev, 32'h0);
    check("arst_valid", {31'b0, pc_valid}, 32'd0);
    check("arst_bad", bad_addr, 32'h0);
    step();
    reset = 1'b1;
    check("reboot_valid", {31'b0, pc_valid}, 32'd0);
    step();
    check("reboot_run", {31'b0, pc_valid}, 32'd1);
    check("reboot_out", out, 32'h0);
    step();
    check("reboot_adv", out, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
